// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM with combinational reads, plus a small
// MMIO window (LED register, free-running cycle counter, sticky misalignment status).
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int MMIO_BIT    = 31
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [1:0]  size,
    output logic [31:0] rdata,
    output logic [7:0]  led_out,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [AW-1:0] word_idx;
    logic [3:0]    mmio_off;
    logic          is_mmio;
    logic          is_byte;
    logic          is_half;
    logic          is_word;
    logic          misaligned;
    logic          store_ok;
    logic [3:0]    lane_we;
    logic [31:0]   ram_word;
    logic [31:0]   mmio_word;
    logic [31:0]   src_word;
    logic          unused_addr;

    logic [7:0]    led_reg, led_next;
    logic [31:0]   cnt_reg, cnt_next;
    logic          err_reg, err_next;

    assign word_idx    = addr[AW+1:2];
    assign mmio_off    = addr[3:0];
    assign is_mmio     = addr[MMIO_BIT];
    assign is_byte     = (size == 2'b00);
    assign is_half     = (size == 2'b01);
    assign is_word     = size[1];
    assign misaligned  = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    assign store_ok    = resetn && we && !misaligned;
    // Address bits between the RAM index and MMIO_BIT are intentionally ignored (wrap).
    assign unused_addr = ^addr;

    // One byte-wide array per lane so partial stores touch only their lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] lane_wdata;

            always_comb begin
                lane_wdata = wdata[8*gi +: 8];
                if (is_byte) begin
                    lane_wdata = wdata[7:0];
                end else if (is_half) begin
                    lane_wdata = LANE[0] ? wdata[15:8] : wdata[7:0];
                end
            end

            assign lane_we[gi] = store_ok && !is_mmio &&
                                 (is_word ||
                                  (is_half && (addr[1] == LANE[1])) ||
                                  (is_byte && (addr[1:0] == LANE)));

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    mem[word_idx] <= lane_wdata;
                end
            end

            assign ram_word[8*gi +: 8] = mem[word_idx];
        end
    endgenerate

    always_comb begin
        led_next = led_reg;
        err_next = err_reg;
        cnt_next = cnt_reg + 32'd1;
        if (store_ok && is_mmio && (mmio_off == 4'h0)) begin
            led_next = wdata[7:0];
        end
        if (store_ok && is_mmio && (mmio_off == 4'h8) && is_word && wdata[0]) begin
            err_next = 1'b0;
        end
        // A misaligned store wins over a status clear in the same cycle.
        if (we && misaligned) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            led_reg <= 8'h00;
            cnt_reg <= 32'd0;
            err_reg <= 1'b0;
        end else begin
            led_reg <= led_next;
            cnt_reg <= cnt_next;
            err_reg <= err_next;
        end
    end

    always_comb begin
        mmio_word = 32'd0;
        case (mmio_off)
            4'h0:    mmio_word = {24'd0, led_reg};
            4'h4:    mmio_word = cnt_reg;
            4'h8:    mmio_word = {31'd0, err_reg};
            default: mmio_word = 32'd0;
        endcase
    end

    assign src_word = is_mmio ? mmio_word : ram_word;

    always_comb begin
        rdata = 32'd0;
        if (!misaligned) begin
            if (is_byte) begin
                rdata = {24'd0, src_word[{addr[1:0], 3'b000} +: 8]};
            end else if (is_half) begin
                rdata = {16'd0, (addr[1] ? src_word[31:16] : src_word[15:0])};
            end else begin
                rdata = src_word;
            end
        end
    end

    assign led_out = led_reg;
    assign err     = err_reg;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder: a byte-array reference model
// predicts rdata/led/err; a negedge monitor pops and compares.
module tb_dmem_responder;
    localparam int DEPTH = 64;
    localparam int BYTES = 4 * DEPTH;

    logic        clk;
    logic        resetn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
    logic [31:0] rdata;
    logic [7:0]  led_out;
    logic        err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BIT(31)) dut (
        .clk(clk), .resetn(resetn), .addr(addr), .wdata(wdata), .we(we),
        .size(size), .rdata(rdata), .led_out(led_out), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [7:0]  led;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    logic chk_valid;
    int   n_cmp;
    int   n_bad;

    // Reference state
    logic [7:0]  mem_m [BYTES];
    logic [7:0]  led_m;
    logic        err_m;
    logic [31:0] cnt_m;

    // Counter: cycles elapsed since the last edge that saw reset.
    always @(posedge clk) begin
        if (!resetn) cnt_m <= 32'd0;
        else         cnt_m <= cnt_m + 32'd1;
    end

    function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] v;
        int idx;
        v = 32'd0;
        if (is_mis(a, sz)) return 32'd0;
        if (a[31]) begin
            case (a[3:0])
                4'h0: v = {24'd0, led_m};
                4'h4: v = cnt_m;
                4'h8: v = {31'd0, err_m};
                default: v = 32'd0;
            endcase
            return v;
        end
        idx = int'(a % BYTES);
        for (int k = 0; k < nbytes(sz); k++) v = v | (32'(mem_m[idx + k]) << (8 * k));
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int idx;
        if (is_mis(a, sz)) begin
            err_m = 1'b1;
        end else if (a[31]) begin
            if (a[3:0] == 4'h0) led_m = wd[7:0];
            if (a[3:0] == 4'h8 && sz[1] && wd[0]) err_m = 1'b0;
        end else begin
            idx = int'(a % BYTES);
            for (int k = 0; k < nbytes(sz); k++) mem_m[idx + k] = wd[8*k +: 8];
        end
    endtask

    // One bus cycle. If chk, the expected read (model or a fixed constant) is queued.
    task automatic xact(input logic [31:0] a, input logic [1:0] sz, input bit w,
                        input logic [31:0] wd, input bit chk, input bit use_const,
                        input logic [31:0] want, input string nm);
        exp_t e;
        addr  = a;
        size  = sz;
        we    = w;
        wdata = wd;
        if (chk) begin
            e.name  = nm;
            e.rdata = use_const ? want : model_read(a, sz);
            e.led   = led_m;
            e.err   = err_m;
            exp_q.push_back(e);
        end
        chk_valid = chk;
        @(posedge clk);
        if (!resetn) begin
            led_m = 8'h00;
            err_m = 1'b0;
        end else if (w) begin
            model_store(a, sz, wd);
        end
        #1;
        chk_valid = 1'b0;
        we        = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] want, input string nm);
        xact(a, sz, 1'b0, 32'd0, 1'b1, 1'b1, want, nm);
    endtask

    task automatic wr(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd, input string nm);
        xact(a, sz, 1'b1, wd, 1'b1, 1'b0, 32'd0, nm);
    endtask

    always @(negedge clk) begin
        if (chk_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL queue_underflow: monitor saw a check with empty scoreboard");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp += 3;
                if (rdata !== e.rdata) begin
                    n_bad++;
                    $display("FAIL %s rdata: got %08h want %08h", e.name, rdata, e.rdata);
                end
                if (led_out !== e.led) begin
                    n_bad++;
                    $display("FAIL %s led_out: got %02h want %02h", e.name, led_out, e.led);
                end
                if (err !== e.err) begin
                    n_bad++;
                    $display("FAIL %s err: got %0b want %0b", e.name, err, e.err);
                end
                $display("chk %-12s addr=%08h size=%0d we=%0b rdata=%08h led=%02h err=%0b",
                         e.name, addr, size, we, rdata, led_out, err);
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        n_cmp     = 0;
        n_bad     = 0;
        chk_valid = 1'b0;
        resetn    = 1'b0;
        addr      = 32'd0;
        wdata     = 32'd0;
        we        = 1'b0;
        size      = 2'b10;
        led_m     = 8'h00;
        err_m     = 1'b0;
        for (int i = 0; i < BYTES; i++) mem_m[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        xact(32'h8000_0000, 2'b10, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0, "reset_led");
        resetn = 1'b1;

        for (int i = 0; i < DEPTH; i++)
            xact(32'(4 * i), 2'b10, 1'b1, $urandom, 1'b0, 1'b0, 32'd0, "init");

        // Lane merge
        wr(32'h10, 2'b10, 32'hDEAD_BEEF, "st_word10");
        wr(32'h12, 2'b00, 32'h0000_0055, "st_byte12");
        rd(32'h10, 2'b10, 32'hDE55_BEEF, "rd_word10");
        rd(32'h12, 2'b01, 32'h0000_DE55, "rd_half12");
        rd(32'h13, 2'b00, 32'h0000_00DE, "rd_byte13");
        // Wrap
        wr(32'h04, 2'b10, 32'h1234_5678, "st_word04");
        wr(32'h04 + 4 * DEPTH, 2'b10, 32'h0, "st_wrap");
        rd(32'h04, 2'b10, 32'h0, "rd_wrap");
        // Misalignment and status clear
        wr(32'h20, 2'b10, 32'h0BAD_F00D, "st_word20");
        xact(32'h21, 2'b01, 1'b1, 32'h0000_AAAA, 1'b1, 1'b1, 32'h0, "st_mis_half");
        rd(32'h20, 2'b10, 32'h0BAD_F00D, "rd_unchanged");
        rd(32'h8000_0008, 2'b10, 32'h1, "rd_err_set");
        wr(32'h8000_0008, 2'b10, 32'h1, "clr_err");
        rd(32'h8000_0008, 2'b10, 32'h0, "rd_err_clr");
        // LED then reset
        wr(32'h8000_0000, 2'b10, 32'h0000_01FF, "st_led");
        rd(32'h8000_0000, 2'b10, 32'h0000_00FF, "rd_led");
        resetn = 1'b0;
        xact(32'h10, 2'b10, 1'b1, 32'h0, 1'b0, 1'b0, 32'd0, "rst_store");
        resetn = 1'b1;
        // Counter after release
        repeat (5) xact(32'h0, 2'b10, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, "idle");
        rd(32'h8000_0004, 2'b10, 32'd5, "rd_cnt5");
        xact(32'h8000_0004, 2'b10, 1'b1, 32'h0, 1'b1, 1'b1, 32'd6, "st_cnt");
        rd(32'h8000_0004, 2'b10, 32'd7, "rd_cnt7");
        rd(32'h8000_0000, 2'b10, 32'h0, "rd_led_rst");
        rd(32'h10, 2'b10, 32'hDE55_BEEF, "rd_ram_kept");
        // Set dominates clear
        wr(32'h3, 2'b10, 32'hFFFF_FFFF, "st_mis_word");
        xact(32'h8000_000A, 2'b10, 1'b1, 32'h1, 1'b1, 1'b1, 32'h0, "mis_clr");
        rd(32'h8000_0008, 2'b10, 32'h1, "rd_err_kept");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 15) begin
                a  = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 2);
                sz = 2'b10;
            end else begin
                a  = 32'($urandom_range(0, 8 * DEPTH - 1));
                sz = 2'($urandom_range(0, 3));
            end
            xact(a, sz, 1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b0, 32'd0, "rand");
        end

        xact(32'h0, 2'b10, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, "idle");
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
